// File: rtl/lsu_rmw_ctrl.sv
// Load/store alignment controller in front of a word-only data memory.
// Sub-word stores become read-modify-write; loads are lane-extracted and extended.
module lsu_rmw_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic              legal;
    logic              aligned;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign req_ready  = (state == IDLE) && !reset;
    assign mem_funct3 = 3'b010;

    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        if (req_we)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        case (req_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane merge for SB/SH, both from the raw read word.
    always_comb begin
        byte_sel  = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_data = '0;
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
        merged = mem_rdata;
        if (!f3_q[0])
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            lane_q          <= 2'b00;
            wdata_q         <= 16'd0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (!(legal && aligned)) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_misaligned <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[DM_ADDRESS-1:2], 2'b00};
                            if (req_we && req_funct3 == 3'b010) begin
                                state     <= WRITE;
                                mem_write <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                state    <= RD_ISSUE;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    mem_read <= 1'b0;
                    if (we_q) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state           <= RESP;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= load_data;
                        resp_misaligned <= 1'b0;
                    end
                end
                WRITE: begin
                    state           <= RESP;
                    mem_write       <= 1'b0;
                    mem_wdata       <= '0;
                    resp_valid      <= 1'b1;
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_rmw_ctrl.md
# lsu_rmw_ctrl

Load/store alignment controller sitting directly upstream of the data memory in the MEM stage. Accepts one load or store request at a time from EX/MEM over a valid/ready handshake. Issues word-only accesses to the data memory, performing read-modify-write for SB/SH and lane extraction with sign/zero extension for loads. Misaligned or illegal accesses are rejected without touching memory and flagged in the response.

## Interface
- DM_ADDRESS, 9: byte-address width into the data memory
- DATA_W, 32: data width (block is defined for 32 only)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and not in reset
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (bits 14:12 of the instruction)
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load result; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid; access was misaligned or illegal
- mem_read  out  1  word read strobe to data memory
- mem_write  out  1  word write strobe to data memory
- mem_addr  out  DM_ADDRESS  word-aligned address, {req_addr[DM_ADDRESS-1:2], 2'b00}
- mem_wdata  out  DATA_W  full word to write
- mem_funct3  out  3  constant 3'b010 (word access)
- mem_rdata  in  DATA_W  word read data from data memory

## Operation
- Handshake: transfer when req_valid && req_ready at a rising edge. All request fields are latched. No response backpressure: the consumer must take resp_valid when it pulses.
- Legal loads: LB 000 and LH 001 (sign-extend), LW 010, LBU 100 and LHU 101 (zero-extend). Legal stores: SB 000, SH 001, SW 010.
- Any other funct3 is illegal.
- Alignment rules:
  - Halfword: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
  - Byte: always aligned.
- Lane k is bits 8k+7:8k.
  - Byte ops use lane addr[1:0].
  - Half ops use lanes {2·addr[1]+1, 2·addr[1]}.
- States:
  - IDLE: req_ready=1. On accept:
    - illegal or misaligned -> RESP with error
    - SW -> WRITE
    - any load, SB, SH -> RD_ISSUE
  - RD_ISSUE: mem_read=1 -> RD_WAIT.
  - RD_WAIT: mem_read=1. mem_rdata is captured at the closing edge. Loads -> RESP. SB/SH -> WRITE.
  - WRITE: mem_write=1. mem_wdata is one of:
    - SW: req_wdata
    - SB/SH: captured word with the addressed lane(s) replaced by req_wdata[7:0] / req_wdata[15:0]
    - Then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- mem_read and mem_write are never both high.
- mem_wdata is 0 outside WRITE.
- mem_addr is held from RD_ISSUE through WRITE.
- resp_rdata and resp_misaligned are registered. They hold until the next RESP.

## Timing
- Latency from the accept edge (edge 0) to the edge at which resp_valid is high:
  - Error: 1 cycle
  - SW: 2 cycles
  - Loads: 3 cycles
  - SB/SH: 4 cycles
- Throughput: the next request can be accepted in the cycle after RESP (IDLE). There is no overlap.
- Memory read contract: mem_rdata is valid for sampling at the edge ending the second cycle of mem_read.
- Reset values: state IDLE, all outputs 0 (req_ready=0 while reset is high, 1 on the first cycle after).
- Reset mid-operation, including between RD_WAIT and WRITE: the operation is abandoned. No mem_write follows and no resp_valid is produced.
- A request presented while not in IDLE is ignored (req_ready=0). The requester must hold it.

## Test plan
- Preload word 0x010 = 0x8899AABB. LB @0x011 -> resp_rdata 0xFFFFFFAA, latency 3, mem_addr 0x010, two mem_read cycles.
- Same word: LHU @0x012 -> 0x00008899. LH @0x012 -> 0xFFFF8899. LW @0x010 -> 0x8899AABB.
- SB @0x013 with wdata 0x12345677 -> single mem_write of 0x7799AABB to 0x010, resp_valid at cycle 4, resp_rdata 0.
- SH @0x011 and LW @0x012 -> resp_misaligned=1 at cycle 1, no mem_read or mem_write. req_funct3=011 load gives the same result.
- Back-to-back SW @0x020 = 0xDEADBEEF then LW @0x020 -> second request accepted the cycle after the first RESP and returns 0xDEADBEEF.
- Assert reset during the RD_WAIT of an SB -> no mem_write and no resp_valid. All outputs 0 during reset; req_ready=1 on the following cycle.
